// File: rtl/mmu_tlb_pkg.sv
// Shared definitions for the Sv32 TLB: satp/PTE field positions, entry
// layout and FSM encodings.
package mmu_tlb_pkg;

  localparam int SATP_MODE_BIT = 31;
  localparam int SATP_ASID_MSB = 30;
  localparam int SATP_ASID_LSB = 22;

  localparam int PAGE_OFFSET_W = 12;
  localparam int PAGE_VPN_MSB  = 31;
  localparam int PAGE_VPN_LSB  = 12;
  localparam int PAGE_PPN_MSB  = 29;
  localparam int PAGE_PPN_LSB  = 10;
  localparam int PAGE_G        = 5;

  localparam int VPN_W   = 20;
  localparam int PPN_W   = 20;
  localparam int ASID_W  = 9;
  localparam int FLAGS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } tlb_state_e;

  typedef struct packed {
    logic               valid;
    logic [VPN_W-1:0]   vpn;
    logic [ASID_W-1:0]  asid;
    logic [PPN_W-1:0]   ppn;
    logic [FLAGS_W-1:0] flags;
  } tlb_entry_t;

  // A 34-bit Sv32 PA is truncated to 32 bits, so only PTE[29:10] survive.
  function automatic logic [PPN_W-1:0] pte_ppn(input logic [31:0] pte);
    return pte[PAGE_PPN_MSB:PAGE_PPN_LSB];
  endfunction

endpackage

// File: rtl/mmu_tlb_cam.sv
// Fully-associative entry array with parallel tag match, lowest-index hit
// priority and first-invalid search for victim selection.
module mmu_tlb_cam
  import mmu_tlb_pkg::*;
#(
  parameter int ENTRIES = 8,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [VPN_W-1:0]   lookup_vpn,
  input  logic [ASID_W-1:0]  lookup_asid,
  input  logic               flush,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  tlb_entry_t         wr_entry,
  output logic               hit,
  output logic [PPN_W-1:0]   hit_ppn,
  output logic [FLAGS_W-1:0] hit_flags,
  output logic               has_invalid,
  output logic [IDX_W-1:0]   inv_idx
);

  tlb_entry_t entry_reg [ENTRIES];
  logic [ENTRIES-1:0] match;
  logic [IDX_W-1:0] hit_idx;

  // Flush has priority over a coincident write so the entry stays invalid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) entry_reg[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) entry_reg[i].valid <= 1'b0;
    end else if (wr_en) begin
      entry_reg[wr_idx] <= wr_entry;
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
    assign match[gi] = entry_reg[gi].valid &&
                       (entry_reg[gi].vpn == lookup_vpn) &&
                       ((entry_reg[gi].asid == lookup_asid) || entry_reg[gi].flags[PAGE_G]);
  end

  // Scanning downward lets the lowest matching index win.
  always_comb begin
    hit         = 1'b0;
    hit_idx     = '0;
    has_invalid = 1'b0;
    inv_idx     = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!entry_reg[i].valid) begin
        has_invalid = 1'b1;
        inv_idx     = IDX_W'(i);
      end
    end
  end

  assign hit_ppn   = entry_reg[hit_idx].ppn;
  assign hit_flags = entry_reg[hit_idx].flags;

endmodule

// File: rtl/mmu_tlb.sv
// Sv32 TLB: hit/bare responses in one cycle, misses forwarded to the
// page-table walker and filled on its completion.
module mmu_tlb
  import mmu_tlb_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        satp_i,
  input  logic               flush_i,
  input  logic               lookup_valid_i,
  input  logic [31:0]        lookup_vaddr_i,
  output logic               lookup_ready_o,
  output logic               resp_valid_o,
  output logic [31:0]        resp_paddr_o,
  output logic [FLAGS_W-1:0] resp_flags_o,
  output logic               resp_fault_o,
  output logic               ptw_req_valid_o,
  output logic [31:0]        ptw_req_addr_o,
  input  logic               ptw_update_i,
  input  logic [31:0]        ptw_vpn_i,
  input  logic [31:0]        ptw_pte_i,
  input  logic               ptw_fault_i
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_e         state_reg;
  logic [31:0]        va_reg;
  logic               drop_reg;
  logic [IDX_W-1:0]   rr_reg;
  logic               ready_reg;
  logic               resp_valid_reg;
  logic [31:0]        resp_paddr_reg;
  logic [FLAGS_W-1:0] resp_flags_reg;
  logic               resp_fault_reg;
  logic               ptw_req_valid_reg;
  logic [31:0]        ptw_req_addr_reg;

  logic               bare;
  logic [ASID_W-1:0]  cur_asid;
  logic               cam_hit;
  logic [PPN_W-1:0]   cam_ppn;
  logic [FLAGS_W-1:0] cam_flags;
  logic               cam_has_invalid;
  logic [IDX_W-1:0]   cam_inv_idx;
  logic               fill_en;
  logic [IDX_W-1:0]   fill_idx;
  tlb_entry_t         fill_entry;
  logic               unused_bits;

  assign bare     = ~satp_i[SATP_MODE_BIT];
  assign cur_asid = satp_i[SATP_ASID_MSB:SATP_ASID_LSB];

  assign fill_en  = (state_reg == ST_WAIT) && !bare && ptw_update_i &&
                    !ptw_fault_i && !drop_reg && !flush_i;
  assign fill_idx = cam_has_invalid ? cam_inv_idx : rr_reg;

  always_comb begin
    fill_entry       = '0;
    fill_entry.valid = 1'b1;
    fill_entry.vpn   = ptw_vpn_i[VPN_W-1:0];
    fill_entry.asid  = cur_asid;
    fill_entry.ppn   = pte_ppn(ptw_pte_i);
    fill_entry.flags = ptw_pte_i[FLAGS_W-1:0];
  end

  assign unused_bits = ^{satp_i[SATP_ASID_LSB-1:0], ptw_vpn_i[31:VPN_W],
                         ptw_pte_i[31:PAGE_PPN_MSB+1], ptw_pte_i[PAGE_PPN_LSB-1:FLAGS_W]};

  mmu_tlb_cam #(.ENTRIES(ENTRIES)) u_cam (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_vpn  (lookup_vaddr_i[PAGE_VPN_MSB:PAGE_VPN_LSB]),
    .lookup_asid (cur_asid),
    .flush       (flush_i),
    .wr_en       (fill_en),
    .wr_idx      (fill_idx),
    .wr_entry    (fill_entry),
    .hit         (cam_hit),
    .hit_ppn     (cam_ppn),
    .hit_flags   (cam_flags),
    .has_invalid (cam_has_invalid),
    .inv_idx     (cam_inv_idx)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg         <= ST_IDLE;
      va_reg            <= '0;
      drop_reg          <= 1'b0;
      rr_reg            <= '0;
      ready_reg         <= 1'b1;
      resp_valid_reg    <= 1'b0;
      resp_paddr_reg    <= '0;
      resp_flags_reg    <= '0;
      resp_fault_reg    <= 1'b0;
      ptw_req_valid_reg <= 1'b0;
      ptw_req_addr_reg  <= '0;
    end else begin
      resp_valid_reg    <= 1'b0;
      ptw_req_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (lookup_valid_i) begin
            if (bare) begin
              resp_valid_reg <= 1'b1;
              resp_paddr_reg <= lookup_vaddr_i;
              resp_flags_reg <= '0;
              resp_fault_reg <= 1'b0;
            end else if (cam_hit) begin
              resp_valid_reg <= 1'b1;
              resp_paddr_reg <= {cam_ppn, lookup_vaddr_i[PAGE_OFFSET_W-1:0]};
              resp_flags_reg <= cam_flags;
              resp_fault_reg <= 1'b0;
            end else begin
              va_reg            <= lookup_vaddr_i;
              ptw_req_addr_reg  <= lookup_vaddr_i;
              ptw_req_valid_reg <= 1'b1;
              drop_reg          <= 1'b0;
              ready_reg         <= 1'b0;
              state_reg         <= ST_REQ;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          if (flush_i) drop_reg <= 1'b1;
          // Leaving translated mode abandons the walk with a bare answer.
          if (bare) begin
            resp_valid_reg <= 1'b1;
            resp_paddr_reg <= va_reg;
            resp_flags_reg <= '0;
            resp_fault_reg <= 1'b0;
            ready_reg      <= 1'b1;
            state_reg      <= ST_IDLE;
          end else if (state_reg == ST_REQ) begin
            state_reg <= ST_WAIT;
          end else if (ptw_update_i) begin
            resp_valid_reg <= 1'b1;
            resp_fault_reg <= ptw_fault_i;
            resp_paddr_reg <= ptw_fault_i ? 32'h0 :
                              {pte_ppn(ptw_pte_i), va_reg[PAGE_OFFSET_W-1:0]};
            resp_flags_reg <= ptw_fault_i ? '0 : ptw_pte_i[FLAGS_W-1:0];
            ready_reg      <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= ST_IDLE;
        end
      endcase
      if (fill_en && !cam_has_invalid) rr_reg <= rr_reg + 1'b1;
    end
  end

  assign lookup_ready_o  = ready_reg;
  assign resp_valid_o    = resp_valid_reg;
  assign resp_paddr_o    = resp_paddr_reg;
  assign resp_flags_o    = resp_flags_reg;
  assign resp_fault_o    = resp_fault_reg;
  assign ptw_req_valid_o = ptw_req_valid_reg;
  assign ptw_req_addr_o  = ptw_req_addr_reg;

endmodule

// File: tb/tb_mmu_tlb.sv
// Directed and randomized checks of mmu_tlb against an array-based TLB model,
// with the bench acting as the page-table walker.
module tb_mmu_tlb;
  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] satp;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_vaddr;
  logic        lookup_ready_o;
  logic        resp_valid_o;
  logic [31:0] resp_paddr_o;
  logic [7:0]  resp_flags_o;
  logic        resp_fault_o;
  logic        ptw_req_valid_o;
  logic [31:0] ptw_req_addr_o;
  logic        ptw_update;
  logic [31:0] ptw_vpn;
  logic [31:0] ptw_pte;
  logic        ptw_fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmu_tlb #(.ENTRIES(ENTRIES)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .satp_i          (satp),
    .flush_i         (flush),
    .lookup_valid_i  (lookup_valid),
    .lookup_vaddr_i  (lookup_vaddr),
    .lookup_ready_o  (lookup_ready_o),
    .resp_valid_o    (resp_valid_o),
    .resp_paddr_o    (resp_paddr_o),
    .resp_flags_o    (resp_flags_o),
    .resp_fault_o    (resp_fault_o),
    .ptw_req_valid_o (ptw_req_valid_o),
    .ptw_req_addr_o  (ptw_req_addr_o),
    .ptw_update_i    (ptw_update),
    .ptw_vpn_i       (ptw_vpn),
    .ptw_pte_i       (ptw_pte),
    .ptw_fault_i     (ptw_fault)
  );

  // Reference TLB contents
  logic        m_valid [ENTRIES];
  logic [19:0] m_vpn   [ENTRIES];
  logic [8:0]  m_asid  [ENTRIES];
  logic [19:0] m_ppn   [ENTRIES];
  logic [7:0]  m_flags [ENTRIES];
  int          m_rr;

  function automatic logic [31:0] satp_of(input int asid);
    return 32'h8000_0000 | (32'(asid) << 22);
  endfunction

  function automatic int m_find(input logic [31:0] va, input logic [31:0] s);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == va[31:12] && (m_asid[i] == s[30:22] || m_flags[i][5]))
        return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_fill(input logic [19:0] vpn, input logic [8:0] asid, input logic [31:0] pte);
    int v;
    v = -1;
    for (int i = 0; i < ENTRIES; i++) if (!m_valid[i] && v < 0) v = i;
    if (v < 0) begin
      v    = m_rr;
      m_rr = (m_rr + 1) % ENTRIES;
    end
    m_valid[v] = 1'b1;
    m_vpn[v]   = vpn;
    m_asid[v]  = asid;
    m_ppn[v]   = pte[29:10];
    m_flags[v] = pte[7:0];
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("resp_pulse", resp_valid_o, 0);
      check("ptw_quiet", ptw_req_valid_o, 0);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_clear();
  endtask

  // mode: 0 plain walk, 1 flush while waiting, 2 flush on the fill edge,
  // 3 satp drops to bare while waiting.
  task automatic do_lookup(input logic [31:0] va, input logic [31:0] pte,
                           input bit wfault, input int mode, input int delay);
    int          idx;
    bit          is_bare;
    logic [31:0] exp_pa;
    logic [7:0]  exp_fl;
    logic [31:0] saved;
    check("ready_idle", lookup_ready_o, 1);
    is_bare      = !satp[31];
    idx          = is_bare ? -1 : m_find(va, satp);
    lookup_valid = 1'b1;
    lookup_vaddr = va;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    if (is_bare || idx >= 0) begin
      exp_pa = is_bare ? va : {m_ppn[idx], va[11:0]};
      exp_fl = is_bare ? 8'h00 : m_flags[idx];
      check("hit_valid", resp_valid_o, 1);
      check("hit_paddr", resp_paddr_o, exp_pa);
      check("hit_flags", resp_flags_o, exp_fl);
      check("hit_fault", resp_fault_o, 0);
      check("hit_no_walk", ptw_req_valid_o, 0);
      $display("[TB] lookup va=%h %s paddr=%h flags=%h", va, is_bare ? "bare" : "hit",
               resp_paddr_o, resp_flags_o);
      return;
    end
    check("miss_no_resp", resp_valid_o, 0);
    check("miss_req", ptw_req_valid_o, 1);
    check("miss_addr", ptw_req_addr_o, va);
    check("miss_busy", lookup_ready_o, 0);
    @(posedge clk); #1;
    check("req_pulse", ptw_req_valid_o, 0);
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
      check("wait_busy", lookup_ready_o, 0);
    end
    check("wait_addr", ptw_req_addr_o, va);
    if (mode == 1) begin
      do_flush();
      check("flush_wait_no_resp", resp_valid_o, 0);
    end
    if (mode == 3) begin
      saved = satp;
      satp  = 32'h0;
      @(posedge clk); #1;
      satp = saved;
      check("abandon_valid", resp_valid_o, 1);
      check("abandon_paddr", resp_paddr_o, va);
      check("abandon_flags", resp_flags_o, 0);
      check("abandon_fault", resp_fault_o, 0);
      check("abandon_ready", lookup_ready_o, 1);
      $display("[TB] lookup va=%h abandoned paddr=%h", va, resp_paddr_o);
      return;
    end
    ptw_update = 1'b1;
    ptw_vpn    = {12'h0, va[31:12]};
    ptw_pte    = pte;
    ptw_fault  = wfault;
    if (mode == 2) flush = 1'b1;
    @(posedge clk); #1;
    ptw_update = 1'b0;
    ptw_fault  = 1'b0;
    flush      = 1'b0;
    exp_pa = wfault ? 32'h0 : {pte[29:10], va[11:0]};
    exp_fl = wfault ? 8'h00 : pte[7:0];
    if (mode == 2) m_clear();
    if (!wfault && mode == 0) m_fill(va[31:12], satp[30:22], pte);
    check("walk_valid", resp_valid_o, 1);
    check("walk_paddr", resp_paddr_o, exp_pa);
    check("walk_flags", resp_flags_o, exp_fl);
    check("walk_fault", resp_fault_o, wfault);
    check("walk_ready", lookup_ready_o, 1);
    $display("[TB] lookup va=%h walk mode=%0d fault=%0d paddr=%h flags=%h",
             va, mode, wfault, resp_paddr_o, resp_flags_o);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] vas [3];
    logic [31:0] va, pte, saved;
    int          idx, r;

    rst = 1'b1; satp = 32'h0; flush = 1'b0; lookup_valid = 1'b0; lookup_vaddr = 32'h0;
    ptw_update = 1'b0; ptw_vpn = 32'h0; ptw_pte = 32'h0; ptw_fault = 1'b0;
    m_clear(); m_rr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ready", lookup_ready_o, 1);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_paddr", resp_paddr_o, 0);
    check("rst_flags", resp_flags_o, 0);
    check("rst_fault", resp_fault_o, 0);
    check("rst_req_valid", ptw_req_valid_o, 0);
    check("rst_req_addr", ptw_req_addr_o, 0);
    idle(1);

    // Bare mode passes through
    do_lookup(32'h1234_5678, 32'h0, 0, 0, 0);
    check("bare_paddr_const", resp_paddr_o, 32'h1234_5678);
    idle(1);

    // Miss then hit
    satp = 32'h8000_0100;
    do_lookup(32'h0040_1ABC, 32'h2000_00CF, 0, 0, 1);
    check("fill_paddr_const", resp_paddr_o, 32'h8000_0ABC);
    check("fill_flags_const", resp_flags_o, 32'hCF);
    idle(1);
    do_lookup(32'h0040_1ABC, 32'h0, 0, 0, 0);
    check("rehit_paddr_const", resp_paddr_o, 32'h8000_0ABC);
    idle(1);

    // Faulting walks never fill
    do_lookup(32'h0077_7000, 32'h2000_00CF, 1, 0, 0);
    idle(1);
    do_lookup(32'h0077_7000, 32'h2000_00CF, 1, 0, 2);
    idle(1);

    // ASID and global pages
    satp = satp_of(1);
    do_lookup(32'h0050_0123, 32'h2000_00CF, 0, 0, 0);
    satp = satp_of(2);
    do_lookup(32'h0050_0123, 32'h2000_00EF, 0, 0, 0);
    satp = satp_of(3);
    do_lookup(32'h0050_0456, 32'h0, 0, 0, 0);
    idle(1);

    // Round-robin replacement
    do_flush();
    for (int i = 0; i < 10; i++) do_lookup({20'h10000 + 20'(i), 12'h010}, {2'b0, 20'h30000 + 20'(i), 10'h0CF}, 0, 0, 0);
    do_lookup(32'h1000_0010, 32'h3100_00CF, 0, 0, 0);
    do_lookup(32'h1000_1010, 32'h3110_00CF, 0, 0, 0);
    do_lookup(32'h1000_2010, 32'h0, 0, 0, 0);
    idle(1);

    // Back-to-back hits
    for (int k = 0; k < 3; k++) do_lookup({20'h20000 + 20'(k), 12'h0}, {2'b0, 20'h40000 + 20'(k), 10'h0C7}, 0, 0, 0);
    for (int k = 0; k < 3; k++) vas[k] = {20'h20000 + 20'(k), 12'(k * 16'h111)};
    lookup_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lookup_vaddr = vas[k];
      idx = m_find(vas[k], satp);
      @(posedge clk); #1;
      if (k == 2) lookup_valid = 1'b0;
      check("b2b_valid", resp_valid_o, 1);
      check("b2b_paddr", resp_paddr_o, idx >= 0 ? {m_ppn[idx], vas[k][11:0]} : 32'hFFFF_FFFF);
      check("b2b_ready", lookup_ready_o, 1);
      $display("[TB] b2b lookup va=%h paddr=%h", vas[k], resp_paddr_o);
    end
    idle(1);

    // Flush during wait and on the fill edge
    do_lookup(32'h0060_0000, 32'h2000_04CF, 0, 1, 1);
    do_lookup(32'h2000_0000, 32'h0, 0, 0, 0);
    do_lookup(32'h0061_0000, 32'h2000_08CF, 0, 2, 0);
    do_lookup(32'h0061_0000, 32'h2000_08CF, 0, 0, 0);
    idle(1);

    // Mode drop abandons the walk
    do_lookup(32'h0062_0ABC, 32'h2000_0CCF, 0, 3, 1);
    idle(1);

    // Stray completion in IDLE is ignored
    ptw_update = 1'b1; ptw_vpn = 32'h0006_3000 >> 12; ptw_pte = 32'h2000_00CF;
    @(posedge clk); #1;
    ptw_update = 1'b0;
    check("stray_idle_no_resp", resp_valid_o, 0);
    do_lookup(32'h0063_0000, 32'h2000_10CF, 0, 0, 0);
    idle(1);

    // Reset mid-walk, then a late completion
    lookup_valid = 1'b1; lookup_vaddr = 32'h0064_0000;
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    check("rstwalk_req", ptw_req_valid_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstwalk_ready", lookup_ready_o, 1);
    check("rstwalk_req_addr", ptw_req_addr_o, 0);
    check("rstwalk_paddr", resp_paddr_o, 0);
    rst = 1'b0;
    m_clear(); m_rr = 0;
    ptw_update = 1'b1; ptw_vpn = 32'h0000_0064; ptw_pte = 32'h2000_00CF;
    @(posedge clk); #1;
    ptw_update = 1'b0;
    check("rstwalk_stray", resp_valid_o, 0);
    do_lookup(32'h0064_0000, 32'h2000_14CF, 0, 0, 0);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) satp = satp_of($urandom_range(1, 3));
      va  = {20'h00100 + 20'($urandom_range(0, 11)), 12'($urandom)};
      pte = {$urandom} & 32'hFFFF_FCFF | 32'h1;
      r   = $urandom_range(0, 15);
      saved = satp;
      if (r == 15) satp = 32'h0;
      do_lookup(va, pte, $urandom_range(0, 7) == 0, r == 0 ? 1 : r == 1 ? 2 : r == 2 ? 3 : 0,
                $urandom_range(0, 3));
      satp = saved;
      idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
